dsp_capture: RTL and testbench

- Parametrised successor of the single-channel DSP chain.
- Offset-binary ADC samples pass through three stages: signed conversion, a selectable boxcar averaging filter, and conversion back to offset binary.
- Filtered samples are written into a circular capture RAM.
- A pretrigger/arm/trigger state machine freezes a record that is read out by address for the UART transmitter.

---
 rtl/dsp_capture.sv | 196 +++++++++++++++++++
 tb/tb_dsp_capture.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_capture.sv
// Offset-binary sample chain (signed conversion, boxcar filter, back to offset binary)
// feeding a circular capture RAM frozen by a pretrigger/arm/trigger state machine.
module dsp_capture #(
    parameter int DATA_W     = 14,
    parameter int RECORD_LEN = 1000,
    parameter int PRETRIG    = 100,
    parameter int AVG_LOG2   = 2,
    parameter int ADDR_W     = 10
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              trigger,
    input  logic              filter_en,
    input  logic              arm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);

    localparam int TAPS     = 1 << AVG_LOG2;
    localparam int SUM_W    = DATA_W + AVG_LOG2;
    localparam int POST_LEN = RECORD_LEN - PRETRIG;
    localparam int PRE_LAST = (PRETRIG > 0) ? PRETRIG - 1 : 0;

    localparam logic [ADDR_W-1:0] PRE_LAST_C  = ADDR_W'(PRE_LAST);
    localparam logic [ADDR_W-1:0] POST_LAST_C = ADDR_W'(POST_LEN - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST_C  = ADDR_W'(RECORD_LEN - 1);
    localparam logic [ADDR_W:0]   LEN_C       = (ADDR_W + 1)'(RECORD_LEN);
    localparam logic [ADDR_W:0]   OFF_C       = (ADDR_W + 1)'(RECORD_LEN - PRETRIG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    // sample_valid qualifies sample_in and trigger on the same cycle; there is no backpressure.
    logic signed [DATA_W-1:0] s1;
    logic signed [DATA_W-1:0] s2;
    logic signed [DATA_W-1:0] taps [TAPS];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  avg_full;
    logic                     trig_q;
    logic                     tag1;
    logic                     tag2;
    logic [DATA_W-1:0]        wr_data;

    always_comb begin
        sum_next = sum + SUM_W'(s1) - SUM_W'(taps[TAPS-1]);
        avg_full = sum_next >>> AVG_LOG2;
        wr_data  = {~s2[DATA_W-1], s2[DATA_W-2:0]};
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            sum    <= '0;
            trig_q <= 1'b0;
            tag1   <= 1'b0;
            tag2   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                taps[i] <= '0;
            end
        end else if (sample_valid) begin
            s1     <= {~sample_in[DATA_W-1], sample_in[DATA_W-2:0]};
            sum    <= sum_next;
            s2     <= filter_en ? avg_full[DATA_W-1:0] : s1;
            trig_q <= trigger;
            tag1   <= trigger & ~trig_q;
            tag2   <= tag1;
            taps[0] <= s1;
            for (int i = TAPS - 1; i > 0; i--) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] trig_ptr;
    logic [ADDR_W-1:0] trig_ptr_next;
    logic              wr_en;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wr_ptr   <= '0;
            trig_ptr <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wr_ptr   <= wr_ptr_next;
            trig_ptr <= trig_ptr_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        trig_ptr_next = trig_ptr;
        wr_en         = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_next = (PRETRIG == 0) ? S_ARMED : S_PRE;
                    cnt_next   = '0;
                end
            end
            S_PRE: begin
                if (sample_valid) begin
                    wr_en    = 1'b1;
                    cnt_next = cnt + 1'b1;
                    if (cnt == PRE_LAST_C) begin
                        state_next = S_ARMED;
                        cnt_next   = '0;
                    end
                end
            end
            S_ARMED: begin
                if (sample_valid) begin
                    wr_en = 1'b1;
                    if (tag2) begin
                        trig_ptr_next = wr_ptr;
                        cnt_next      = 1;
                        state_next    = (POST_LEN == 1) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (sample_valid) begin
                    wr_en    = 1'b1;
                    cnt_next = cnt + 1'b1;
                    if (cnt == POST_LAST_C) begin
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        wr_ptr_next = wr_ptr;
        if (wr_en) begin
            wr_ptr_next = (wr_ptr == PTR_LAST_C) ? '0 : wr_ptr + 1'b1;
        end
    end

    assign busy = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    assign done = (state == S_DONE);

    // Logical index 0 maps to the oldest pretrigger sample; both wraps are a single subtract.
    logic [ADDR_W:0]   base_raw;
    logic [ADDR_W:0]   base;
    logic [ADDR_W:0]   phys_raw;
    logic [ADDR_W:0]   phys;
    logic              rd_oor;
    logic [ADDR_W-1:0] mem_addr;

    always_comb begin
        base_raw = {1'b0, trig_ptr} + OFF_C;
        base     = (base_raw >= LEN_C) ? base_raw - LEN_C : base_raw;
        phys_raw = base + {1'b0, rd_addr};
        phys     = (phys_raw >= LEN_C) ? phys_raw - LEN_C : phys_raw;
        rd_oor   = ({1'b0, rd_addr} >= LEN_C);
        mem_addr = rd_oor ? '0 : phys[ADDR_W-1:0];
    end

    logic [DATA_W-1:0] mem [RECORD_LEN];

    always_ff @(posedge sys_clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_oor) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[mem_addr];
        end
    end

endmodule

// File: tb/tb_dsp_capture.sv
// Directed capture scenarios with randomized sample streams, checked against a
// sample-history model of the filter, trigger alignment and record window.
module tb_dsp_capture;

  localparam int DW   = 14;
  localparam int N    = 1000;
  localparam int PT   = 100;
  localparam int AL   = 2;
  localparam int AW   = 10;
  localparam int TAPS = 1 << AL;
  localparam int MID  = 1 << (DW - 1);

  logic          sys_clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          trigger = 1'b0;
  logic          filter_en = 1'b0;
  logic          arm = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  dsp_capture #(
    .DATA_W(DW), .RECORD_LEN(N), .PRETRIG(PT), .AVG_LOG2(AL), .ADDR_W(AW)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .sample_in(sample_in),
    .sample_valid(sample_valid), .trigger(trigger), .filter_en(filter_en),
    .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // accepted samples and trigger levels since the last reset, one entry per valid cycle
  logic [DW-1:0] xq[$];
  bit            tq[$];
  logic [DW-1:0] exp_q[$];
  int            pre_start = 0;
  int            cur_f = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // reference model
  function automatic int sx(input int n);
    if (n < 0) return 0;
    return int'(xq[n]) - MID;
  endfunction

  function automatic logic [DW-1:0] y_off(input int j);
    int s;
    s = 0;
    if (cur_f != 0) begin
      for (int i = 0; i < TAPS; i++) s += sx(j - i);
      s = s >>> AL;
    end else begin
      s = sx(j);
    end
    return DW'(s + MID);
  endfunction

  function automatic int find_edge();
    bit prev;
    for (int k = 0; k < tq.size(); k++) begin
      prev = (k == 0) ? 1'b0 : tq[k-1];
      if (tq[k] && !prev && (k + 2 >= pre_start + PT)) return k;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] gen(input int mode, input int n);
    int seg;
    int pick;
    if (mode == 0) return DW'(n);
    seg = (n / 40) % 6;
    case (seg)
      0: return 14'd12288;
      2: return 14'd16383;
      3: return 14'd0;
      4: begin
        pick = $urandom_range(0, 2);
        return (pick == 0) ? 14'd0 : (pick == 1) ? 14'd8192 : 14'd16383;
      end
      default: return DW'($urandom_range(0, (1 << DW) - 1));
    endcase
  endfunction

  // drivers
  task automatic step(input bit v, input logic [DW-1:0] x, input bit t, input bit a);
    sample_valid = v;
    sample_in = x;
    trigger = t;
    arm = a;
    @(posedge sys_clk);
    #1;
    arm = 1'b0;
    if (v && !reset) begin
      xq.push_back(x);
      tq.push_back(t);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    arm = 1'b0;
    trigger = 1'b0;
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    xq.delete();
    tq.delete();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
  endtask

  task automatic rd_check(input int a, input logic [DW-1:0] expv, input string tag);
    sample_valid = 1'b0;
    rd_addr = AW'(a);
    @(posedge sys_clk);
    #1;
    check(tag, 32'(rd_data), 32'(expv));
  endtask

  task automatic run_capture(input int f, input int gapped, input int mode, input int trig_rel,
                             input int pre_rel, input int arm_post, input int stop_rel);
    int  trig_m;
    int  pre_m;
    int  n;
    int  m;
    bit  v;
    bit  t;
    bit  a;
    bit  pulsed;
    bit  seen;
    logic [DW-1:0] x;
    cur_f = f;
    filter_en = f[0];
    pulsed = 0;
    seen = 0;
    m = -1;
    step(1'b0, '0, 1'b0, 1'b1);
    pre_start = xq.size();
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_done_clear", 32'(done), 32'd0);
    trig_m = pre_start + trig_rel;
    pre_m = (pre_rel < 0) ? -1000 : pre_start + pre_rel;
    for (int c = 0; c < 5000; c++) begin
      n = xq.size();
      v = (gapped != 0) ? (c % 2 == 0) : 1'b1;
      x = gen(mode, n);
      t = (n >= trig_m) || (n >= pre_m && n < pre_m + 5);
      a = (arm_post != 0) && !pulsed && (n == trig_m + 50);
      if (a) pulsed = 1;
      step(v, x, t, a);
      if (a) check("arm_in_post_ignored", 32'(busy), 32'd1);
      if (stop_rel > 0 && n >= trig_m + stop_rel) begin
        check("abort_busy", 32'(busy), 32'd1);
        return;
      end
      if (done) begin
        m = find_edge();
        check("done_index", 32'(xq.size()), 32'(m + N - PT + 2));
        check("done_busy", 32'(busy), 32'd0);
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    exp_q.delete();
    for (int i = 0; i < (1 << AW); i++) exp_q.push_back((i < N) ? y_off(m - PT + i) : '0);
    for (int i = 0; i < (1 << AW); i++) rd_check(i, exp_q[i], "record");
  endtask

  initial begin
    do_reset();

    // boxcar step from reset, then saturating-range constants and random data
    filter_en = 1'b1;
    do_reset();
    run_capture(1, 0, 1, 98, -1, 0, 0);
    rd_check(0, 14'd8192, "step_0");
    rd_check(2, 14'd9216, "step_1");
    rd_check(3, 14'd10240, "step_2");
    rd_check(4, 14'd11264, "step_3");
    rd_check(5, 14'd12288, "step_4");
    rd_check(30, 14'd12288, "step_steady");

    // bypass with random codes including 0, 8192, 16383
    filter_en = 1'b0;
    do_reset();
    run_capture(0, 0, 1, 300, -1, 0, 0);

    // ramp capture, trigger with sample 500
    do_reset();
    run_capture(0, 0, 0, 500, -1, 0, 0);
    rd_check(0, 14'd400, "ramp_0");
    rd_check(100, 14'd500, "ramp_100");
    rd_check(999, 14'd1399, "ramp_999");
    rd_check(1000, 14'd0, "ramp_oor");

    // trigger during PRE and arm during POST are ignored; then re-arm from DONE
    filter_en = 1'b1;
    do_reset();
    run_capture(1, 0, 1, 400, 50, 1, 0);
    run_capture(1, 0, 1, 200, -1, 0, 0);

    // gapped valid ramp, trigger rising on an invalid cycle
    filter_en = 1'b0;
    do_reset();
    run_capture(0, 1, 0, 500, -1, 0, 0);
    rd_check(0, 14'd400, "gap_0");
    rd_check(100, 14'd500, "gap_100");
    rd_check(999, 14'd1399, "gap_999");

    // reset in the middle of POST, then a complete capture
    do_reset();
    run_capture(0, 0, 1, 300, -1, 0, 200);
    do_reset();
    run_capture(0, 0, 1, 350, -1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
